branch_ctrl: RTL and testbench

Parametrised branch control unit between the instruction ROM, the ALU and the program counter (fetch unit). Latches compare flags from flag-setting instructions, evaluates conditional and unconditional branches against those stored flags, and supplies a branch target from a writable lookup table. After every taken branch it squashes a configurable number of shadow-slot instructions and keeps a saturating count of taken branches.

---
 rtl/branch_ctrl_if.sv | 40 ++++
 rtl/branch_ctrl.sv | 103 ++++++++++
 tb/tb_branch_ctrl.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/branch_ctrl_if.sv
// Signal bundle between branch_ctrl and the fetch/ALU side.
// The fetch/ALU side takes the master view and branch_ctrl the slave view.
interface branch_ctrl_if #(
    parameter int IW        = 9,
    parameter int PCW       = 10,
    parameter int LUT_DEPTH = 16
);
    localparam int IDXW = $clog2(LUT_DEPTH);

    logic [IW-1:0]   Instruction;
    logic            inst_valid;
    logic            stall;
    logic            alu_eq;
    logic            alu_lt;
    logic            lut_we;
    logic [IDXW-1:0] lut_waddr;
    logic [PCW-1:0]  lut_wdata;

    logic            branch_en;
    logic [PCW-1:0]  branch_target;
    logic            flush_o;
    logic            illegal_o;
    logic            flag_eq;
    logic            flag_lt;
    logic [15:0]     taken_count;

    modport master (
        output Instruction, inst_valid, stall, alu_eq, alu_lt,
               lut_we, lut_waddr, lut_wdata,
        input  branch_en, branch_target, flush_o, illegal_o,
               flag_eq, flag_lt, taken_count
    );

    modport slave (
        input  Instruction, inst_valid, stall, alu_eq, alu_lt,
               lut_we, lut_waddr, lut_wdata,
        output branch_en, branch_target, flush_o, illegal_o,
               flag_eq, flag_lt, taken_count
    );
endinterface

// File: rtl/branch_ctrl.sv
// Branch control: stored compare flags, conditional branch decision, target LUT,
// post-branch squash window and a saturating taken-branch counter.
module branch_ctrl #(
    parameter int             IW           = 9,
    parameter int             OPW          = 4,
    parameter int             LUT_DEPTH    = 16,
    parameter int             PCW          = 10,
    parameter int             FLUSH_CYCLES = 1,
    parameter logic [OPW-1:0] OP_CMP       = 'h1,
    parameter logic [OPW-1:0] OP_BEQ       = 'h2,
    parameter logic [OPW-1:0] OP_BNEQ      = 'h3,
    parameter logic [OPW-1:0] OP_BLT       = 'h4,
    parameter logic [OPW-1:0] OP_BGE       = 'h5,
    parameter logic [OPW-1:0] OP_JMP       = 'h6
) (
    input logic         Clk,
    input logic         Reset_n,
    branch_ctrl_if.slave bus
);
    localparam int         IDXW     = $clog2(LUT_DEPTH);
    localparam logic [3:0] FLUSH_LD = 4'(FLUSH_CYCLES);

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    logic [PCW-1:0]  lut [LUT_DEPTH];
    logic [3:0]      sq_cnt;
    logic            flag_eq_q;
    logic            flag_lt_q;
    logic [15:0]     taken_q;

    logic [OPW-1:0]  op;
    logic            br;
    logic [IDXW-1:0] idx;
    logic            flush;
    logic            act;
    logic            legal;
    logic            cond;
    logic            take;

    assign op    = bus.Instruction[IW-2 -: OPW];
    assign br    = bus.Instruction[IW-1];
    assign idx   = bus.Instruction[IDXW-1:0];
    assign flush = (sq_cnt != 4'd0);
    assign act   = bus.inst_valid & ~bus.stall & ~flush;

    // Conditions look only at the stored flags, never the live ALU outputs.
    always_comb begin
        legal = 1'b1;
        cond  = 1'b0;
        case (op)
            OP_BEQ:  cond = flag_eq_q;
            OP_BNEQ: cond = ~flag_eq_q;
            OP_BLT:  cond = flag_lt_q;
            OP_BGE:  cond = ~flag_lt_q;
            OP_JMP:  cond = 1'b1;
            default: legal = 1'b0;
        endcase
    end

    assign take = act & br & legal & cond;

    assign bus.branch_en     = take;
    assign bus.branch_target = lut[idx];
    assign bus.flush_o       = flush;
    assign bus.illegal_o     = bus.inst_valid & ~flush & br & ~legal;
    assign bus.flag_eq       = flag_eq_q;
    assign bus.flag_lt       = flag_lt_q;
    assign bus.taken_count   = taken_q;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            flag_eq_q <= 1'b0;
            flag_lt_q <= 1'b0;
        end else if (act && !br && op == OP_CMP) begin
            flag_eq_q <= bus.alu_eq;
            flag_lt_q <= bus.alu_lt;
        end
    end

    // A taken branch can only occur with the counter at zero, so no reload inside a window.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            sq_cnt  <= 4'd0;
            taken_q <= 16'd0;
        end else if (take) begin
            sq_cnt  <= FLUSH_LD;
            taken_q <= sat_inc(taken_q);
        end else if (!bus.stall && flush) begin
            sq_cnt  <= sq_cnt - 4'd1;
        end
    end

    // Table writes ignore stall and flush; a same-cycle read sees the old entry.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            for (int i = 0; i < LUT_DEPTH; i++) lut[i] <= '0;
        end else if (bus.lut_we) begin
            lut[bus.lut_waddr] <= bus.lut_wdata;
        end
    end
endmodule

// File: tb/tb_branch_ctrl.sv
// Drives three branch_ctrl copies (FLUSH_CYCLES 0, 1, 3) with shared stimulus
// and compares them against a behavioural model of the branch rules.
module tb_branch_ctrl;
    localparam int IW  = 9;
    localparam int PCW = 10;
    localparam int LD  = 16;
    localparam int NC  = 3;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    logic [IW-1:0]  instr;
    logic           valid, stall, aeq, alt, we;
    logic [3:0]     waddr;
    logic [PCW-1:0] wdata;

    logic           be  [NC];
    logic           ill [NC];
    logic           fl  [NC];
    logic           feq [NC];
    logic           flt [NC];
    logic [PCW-1:0] tgt [NC];
    logic [15:0]    tc  [NC];

    for (genvar g = 0; g < NC; g++) begin : g_dut
        branch_ctrl_if #(.IW(IW), .PCW(PCW), .LUT_DEPTH(LD)) bus ();
        assign bus.Instruction = instr;
        assign bus.inst_valid  = valid;
        assign bus.stall       = stall;
        assign bus.alu_eq      = aeq;
        assign bus.alu_lt      = alt;
        assign bus.lut_we      = we;
        assign bus.lut_waddr   = waddr;
        assign bus.lut_wdata   = wdata;
        assign be[g]  = bus.branch_en;
        assign ill[g] = bus.illegal_o;
        assign fl[g]  = bus.flush_o;
        assign feq[g] = bus.flag_eq;
        assign flt[g] = bus.flag_lt;
        assign tgt[g] = bus.branch_target;
        assign tc[g]  = bus.taken_count;
        branch_ctrl #(
            .IW(IW), .PCW(PCW), .LUT_DEPTH(LD),
            .FLUSH_CYCLES((g == 0) ? 0 : (g == 1) ? 1 : 3)
        ) u_dut (
            .Clk(clk), .Reset_n(rst_n), .bus(bus)
        );
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input int obs, input int exp);
        n_tests++;
        if (obs != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
        end
    endtask

    // Behavioural model: flags, remaining squash slots, taken count, table.
    int fcv [NC] = '{0, 1, 3};
    int m_feq [NC];
    int m_flt [NC];
    int m_left [NC];
    int m_taken [NC];
    int m_lut [NC][LD];

    task automatic model_reset();
        for (int k = 0; k < NC; k++) begin
            m_feq[k] = 0; m_flt[k] = 0; m_left[k] = 0; m_taken[k] = 0;
            for (int i = 0; i < LD; i++) m_lut[k][i] = 0;
        end
    endtask

    function automatic logic [IW-1:0] mk(input logic b, input logic [3:0] op, input logic [3:0] idx);
        return {b, op, idx};
    endfunction

    task automatic set_in(input logic [IW-1:0] i, input logic v);
        instr = i; valid = v; stall = 1'b0; we = 1'b0;
    endtask

    // One clock: compare outputs at the falling edge, advance the model, return at posedge+1.
    task automatic step();
        @(negedge clk);
        for (int k = 0; k < NC; k++) begin
            int b, op, idx, flush, act, legal, cond, e_be, e_ill;
            b = int'(instr[8]); op = int'(instr[7:4]); idx = int'(instr[3:0]);
            flush = (m_left[k] > 0) ? 1 : 0;
            act   = (valid && !stall && flush == 0) ? 1 : 0;
            legal = (op >= 2 && op <= 6) ? 1 : 0;
            case (op)
                2: cond = m_feq[k];
                3: cond = 1 - m_feq[k];
                4: cond = m_flt[k];
                5: cond = 1 - m_flt[k];
                6: cond = 1;
                default: cond = 0;
            endcase
            e_be  = (act == 1 && b == 1 && legal == 1 && cond == 1) ? 1 : 0;
            e_ill = (valid && flush == 0 && b == 1 && legal == 0) ? 1 : 0;
            check($sformatf("c%0d.branch_en", k), int'(be[k]), e_be);
            check($sformatf("c%0d.illegal", k), int'(ill[k]), e_ill);
            check($sformatf("c%0d.flush", k), int'(fl[k]), flush);
            check($sformatf("c%0d.flag_eq", k), int'(feq[k]), m_feq[k]);
            check($sformatf("c%0d.flag_lt", k), int'(flt[k]), m_flt[k]);
            check($sformatf("c%0d.taken", k), int'(tc[k]), m_taken[k]);
            if (e_be == 1) check($sformatf("c%0d.target", k), int'(tgt[k]), m_lut[k][idx]);
            if (act == 1 && b == 0 && op == 1) begin
                m_feq[k] = int'(aeq); m_flt[k] = int'(alt);
            end
            if (e_be == 1) begin
                m_left[k] = fcv[k];
                if (m_taken[k] < 65535) m_taken[k]++;
            end else if (!stall && m_left[k] > 0) begin
                m_left[k]--;
            end
            if (we) m_lut[k][waddr] = int'(wdata);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        model_reset();
        for (int k = 0; k < NC; k++) begin
            check($sformatf("c%0d.rst_flush", k), int'(fl[k]), 0);
            check($sformatf("c%0d.rst_feq", k), int'(feq[k]), 0);
            check($sformatf("c%0d.rst_flt", k), int'(flt[k]), 0);
            check($sformatf("c%0d.rst_taken", k), int'(tc[k]), 0);
        end
        #1;
        rst_n = 1'b1;
    endtask

    task automatic idle(input int n);
        set_in('0, 1'b0);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        int fcount;
        instr = '0; valid = 0; stall = 0; aeq = 0; alt = 0;
        we = 0; waddr = '0; wdata = '0;
        #2;
        do_reset();

        // Taken BEQ with target from the table, then an ignored shadow slot
        set_in('0, 1'b0); we = 1'b1; waddr = 4'd5; wdata = 10'h07A; step();
        set_in(mk(1'b0, 4'h1, 4'd0), 1'b1); aeq = 1'b1; alt = 1'b0; step();
        set_in(mk(1'b1, 4'h2, 4'd5), 1'b1); aeq = 1'b0; #1;
        check("beq_taken", int'(be[1]), 1);
        check("beq_target", int'(tgt[1]), 'h07A);
        step();
        check("beq_count", int'(tc[1]), 1);
        check("beq_flush", int'(fl[1]), 1);
        set_in(mk(1'b0, 4'h1, 4'd0), 1'b1); aeq = 1'b0; step();
        check("slot_ignored", int'(feq[1]), 1);
        idle(4);

        // Reset in the middle of a squash window
        set_in(mk(1'b1, 4'h6, 4'd0), 1'b1); step();
        check("pre_rst_flush", int'(fl[1]), 1);
        set_in(mk(1'b1, 4'h6, 4'd3), 1'b1);
        rst_n = 1'b0; #1;
        check("rst_async_flush", int'(fl[1]), 0);
        check("rst_lut3", int'(tgt[1]), 0);
        check("rst_jmp_en", int'(be[1]), 1);
        do_reset();
        idle(4);

        // Conditions use stored flags; live ALU inputs toggle freely
        set_in(mk(1'b0, 4'h1, 4'd0), 1'b1); aeq = 1'b0; alt = 1'b1; step();
        for (int j = 0; j < 4; j++) begin
            int exp_t [4] = '{0, 1, 1, 0};
            set_in(mk(1'b1, 4'(2 + j), 4'(j)), 1'b1);
            aeq = 1'($urandom); alt = 1'($urandom); #1;
            check($sformatf("cond_op%0d", 2 + j), int'(be[0]), exp_t[j]);
            step();
            idle(4);
        end

        // Undefined branch-class opcode
        set_in(mk(1'b1, 4'hF, 4'd1), 1'b1); aeq = 1'b1; alt = 1'b0; #1;
        check("illegal_flag", int'(ill[0]), 1);
        check("illegal_no_br", int'(be[0]), 0);
        step();
        check("illegal_feq_kept", int'(feq[0]), 0);
        check("illegal_flt_kept", int'(flt[0]), 1);
        idle(4);

        // Three-slot window with one stalled cycle and a JMP inside it
        set_in(mk(1'b1, 4'h6, 4'd0), 1'b1); step();
        fcount = 0;
        for (int i = 0; i < 6; i++) begin
            set_in((i == 2) ? mk(1'b1, 4'h6, 4'd1) : '0, (i == 2));
            stall = (i == 1);
            #1;
            fcount += int'(fl[2]);
            if (i == 2) check("jmp_in_window", int'(be[2]), 0);
            step();
        end
        check("flush_len_stall", fcount, 4);
        idle(4);

        // Same-cycle table write and read
        set_in(mk(1'b1, 4'h6, 4'd2), 1'b1);
        we = 1'b1; waddr = 4'd2; wdata = 10'h155; #1;
        check("lut_old_value", int'(tgt[0]), 0);
        step();
        set_in(mk(1'b1, 4'h6, 4'd2), 1'b1); #1;
        check("lut_new_value", int'(tgt[0]), 'h155);
        check("lut_new_en", int'(be[0]), 1);
        step();
        idle(4);

        // Randomized traffic with occasional asynchronous resets
        for (int c = 0; c < 2000; c++) begin
            logic [3:0] op;
            op = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'($urandom_range(1, 6));
            instr = mk(1'($urandom), op, 4'($urandom));
            valid = ($urandom_range(0, 9) < 8);
            stall = ($urandom_range(0, 9) < 2);
            aeq = 1'($urandom); alt = 1'($urandom);
            we = ($urandom_range(0, 4) == 0);
            waddr = 4'($urandom); wdata = 10'($urandom);
            if ($urandom_range(0, 299) == 0) do_reset();
            step();
        end

        // Saturation of the taken counter
        idle(4);
        set_in(mk(1'b1, 4'h6, 4'd0), 1'b1);
        for (int c = 0; c < 65545; c++) step();
        check("taken_saturated", int'(tc[0]), 'hFFFF);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
